controlador_ejecucion: RTL and testbench
========================================

// Module: controlador_ejecucion
// PURPOSE
//  Run/halt/step sequencer for the single-cycle processor. Holds the datapath idle after reset,
//  then gates every architectural commit (PC update, register-file write, data-memory write)
//  via commit_en. Supports free run, N-instruction step bursts and halt on request or halt
//  instruction. Sits between the debug/host interface and procesador_monociclo.
// PARAMETERS
//  ADDR_W   32  PC / breakpoint address width
//  CNT_W    32  width of cycle_count and instr_count
//  RST_HOLD 4   cycles held in HOLD after reset deasserts (memory init settle), >=1
//  BOOT_RUN 0   1: HOLD exits to RUN; 0: HOLD exits to HALTED
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       synchronous, active-high
//  run_req     in   1       1-cycle pulse: HALTED -> RUN
//  halt_req    in   1       1-cycle pulse: RUN/STEP -> HALTED
//  step_req    in   1       1-cycle pulse: HALTED -> STEP, burst length from step_count
//  step_count  in   8       instructions per burst; 0 treated as 1
//  pc          in   ADDR_W  PC of instruction executing this cycle
//  instr_halt  in   1       decoded halt instruction executing this cycle
//  commit_en   out  1       datapath commit enable
//  halted      out  1       state == HALTED
//  state       out  2       HOLD=0 HALTED=1 RUN=2 STEP=3
//  halt_cause  out  2       0 none, 1 halt_req, 2 instr_halt, 3 breakpoint
//  cycle_count out  CNT_W   cycles since reset, wraps
//  instr_count out  CNT_W   committed instructions, wraps
// BEHAVIOUR
//  - Reset: state=HOLD, hold ctr=0, remaining=0, counts=0, halt_cause=0, bp_skip=0.
//    commit_en = 0 whenever reset=1 (combinational gate), so a mid-run reset commits nothing.
//  - commit_en = ~reset & (state==RUN | (state==STEP & remaining!=0)) & ~bp_block.
//    Otherwise Moore: requests take effect the cycle after sampling.
//  - HOLD: all requests ignored; after RST_HOLD cycles -> RUN if BOOT_RUN else HALTED.
//  - HALTED: step_req -> STEP, remaining = max(step_count,1); else run_req -> RUN.
//    step_req wins if both asserted.
//  - RUN/STEP: exit priority halt_req > instr_halt > breakpoint. The instruction executing
//    when halt_req or instr_halt is sampled still commits; next state HALTED, halt_cause
//    updated. run_req/step_req are ignored.
//  - STEP: remaining decrements per commit; a commit with remaining==1 -> HALTED,
//    halt_cause unchanged.
//  - halt_cause holds until the next halt entry; HOLD->HALTED leaves it 0.
//  - cycle_count +1 every non-reset cycle; instr_count +1 per commit_en=1; both wrap to 0.
// CONFIGURATION
//  BREAKPOINT_EN defined: adds inputs bp_valid(1), bp_addr(ADDR_W).
//    bp_block = bp_valid & pc==bp_addr & ~bp_skip & state in {RUN,STEP}.
//    On bp_block the instruction does NOT commit; next state HALTED, halt_cause=3.
//    bp_skip is set on leaving HALTED and cleared after the first commit, so resume passes
//    the breakpoint. bp_block has lowest exit priority.
//  BREAKPOINT_EN undefined: ports absent, bp_block=0, cause 3 never produced.
// STRUCTURE
//  Shared header controlador_ejecucion_defs.vh: state encodings, halt_cause codes.
//  Sub-module comparador_breakpoint (pc/bp_addr/bp_valid/bp_skip -> bp_block), instantiated
//  only under BREAKPOINT_EN. FSM, hold/step counters and stats counters stay in the top level.
// TESTING
//  1 Reset 3 cycles, BOOT_RUN=0 -> commit_en=0 throughout; HALTED 4 cycles after reset falls;
//    counts 0/0 at reset.
//  2 HALTED, run_req, 10 cycles, halt_req -> 11 commits (halt cycle commits), halted,
//    halt_cause=1.
//  3 HALTED, step_req, step_count=3 -> commit_en high exactly 3 cycles, instr_count +3,
//    halted; step_count=0 -> 1 commit.
//  4 RUN, instr_halt at pc=0x20 -> that commit occurs, HALTED, halt_cause=2;
//    run_req+halt_req together in HALTED -> RUN.
//  5 BREAKPOINT_EN, bp_addr=0x10, run -> no commit at pc=0x10, halt_cause=3;
//    run_req -> 0x10 commits, next hit halts again.
//  6 Reset asserted mid-STEP with remaining=5 -> commit_en=0 that cycle, state=HOLD,
//    counts cleared.

Source files
------------

// File: rtl/controlador_ejecucion_pkg.sv
// rtl/controlador_ejecucion_pkg.sv - state encodings, halt causes and step-length helper for controlador_ejecucion
package controlador_ejecucion_pkg;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_HALTED = 2'd1,
        ST_RUN    = 2'd2,
        ST_STEP   = 2'd3
    } estado_t;

    localparam logic [1:0] CAUSA_NINGUNA    = 2'd0;
    localparam logic [1:0] CAUSA_HALT_REQ   = 2'd1;
    localparam logic [1:0] CAUSA_INSTR_HALT = 2'd2;
    localparam logic [1:0] CAUSA_BREAKPOINT = 2'd3;

    // A zero-length burst still executes one instruction.
    function automatic logic [7:0] step_len(input logic [7:0] n);
        return (n == 8'd0) ? 8'd1 : n;
    endfunction

endpackage

// File: rtl/controlador_ejecucion_comparador_breakpoint.sv
// rtl/controlador_ejecucion_comparador_breakpoint.sv - breakpoint match, compiled only with BREAKPOINT_EN
`ifdef BREAKPOINT_EN
module comparador_breakpoint #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_valid,
    input  logic              bp_skip,
    input  logic              en_ejecucion,
    output logic              bp_block
);

    assign bp_block = bp_valid & (pc == bp_addr) & ~bp_skip & en_ejecucion;

endmodule
`endif

// File: rtl/controlador_ejecucion.sv
// rtl/controlador_ejecucion.sv - run/halt/step sequencer gating datapath commits; BREAKPOINT_EN adds a PC breakpoint
module controlador_ejecucion
    import controlador_ejecucion_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 32,
    parameter int RST_HOLD = 4,
    parameter int BOOT_RUN = 0
) (
    input  logic              clk,
    input  logic              reset,
`ifdef BREAKPOINT_EN
    input  logic              bp_valid,
    input  logic [ADDR_W-1:0] bp_addr,
`endif
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [7:0]        step_count,
    input  logic [ADDR_W-1:0] pc,
    input  logic              instr_halt,
    output logic              commit_en,
    output logic              halted,
    output logic [1:0]        state,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    estado_t           estado_q, estado_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        rem_q, rem_d;
    logic [1:0]        causa_q, causa_d;
    logic              skip_q, skip_d;
    logic              bp_block;
    logic              en_ejecucion;
    logic [CNT_W-1:0]  ciclos_q, instr_q;

    assign en_ejecucion = (estado_q == ST_RUN) || (estado_q == ST_STEP);

`ifdef BREAKPOINT_EN
    comparador_breakpoint #(.ADDR_W(ADDR_W)) u_comparador_breakpoint (
        .pc           (pc),
        .bp_addr      (bp_addr),
        .bp_valid     (bp_valid),
        .bp_skip      (skip_q),
        .en_ejecucion (en_ejecucion),
        .bp_block     (bp_block)
    );
`else
    logic unused_bp;
    assign bp_block  = 1'b0;
    assign unused_bp = ^{pc, skip_q};
`endif

    // Reset gates the commit combinationally so a mid-run reset never writes state.
    assign commit_en = ~reset & ~bp_block &
                       ((estado_q == ST_RUN) || ((estado_q == ST_STEP) && (rem_q != 8'd0)));

    always_comb begin
        estado_d = estado_q;
        hold_d   = hold_q;
        rem_d    = rem_q;
        causa_d  = causa_q;
        skip_d   = skip_q;
        case (estado_q)
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    estado_d = (BOOT_RUN != 0) ? ST_RUN : ST_HALTED;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_HALTED: begin
                if (step_req) begin
                    estado_d = ST_STEP;
                    rem_d    = step_len(step_count);
                    skip_d   = 1'b1;
                end else if (run_req) begin
                    estado_d = ST_RUN;
                    skip_d   = 1'b1;
                end
            end
            default: begin
                if (commit_en) begin
                    skip_d = 1'b0;
                    if (estado_q == ST_STEP) rem_d = rem_q - 8'd1;
                end
                if (halt_req) begin
                    estado_d = ST_HALTED;
                    causa_d  = CAUSA_HALT_REQ;
                end else if (instr_halt) begin
                    estado_d = ST_HALTED;
                    causa_d  = CAUSA_INSTR_HALT;
                end else if (bp_block) begin
                    estado_d = ST_HALTED;
                    causa_d  = CAUSA_BREAKPOINT;
                end else if ((estado_q == ST_STEP) && commit_en && (rem_q == 8'd1)) begin
                    estado_d = ST_HALTED;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= ST_HOLD;
            hold_q   <= '0;
            rem_q    <= 8'd0;
            causa_q  <= CAUSA_NINGUNA;
            skip_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            hold_q   <= hold_d;
            rem_q    <= rem_d;
            causa_q  <= causa_d;
            skip_q   <= skip_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ciclos_q <= '0;
            instr_q  <= '0;
        end else begin
            ciclos_q <= ciclos_q + 1'b1;
            if (commit_en) instr_q <= instr_q + 1'b1;
        end
    end

    assign halted      = (estado_q == ST_HALTED);
    assign state       = estado_q;
    assign halt_cause  = causa_q;
    assign cycle_count = ciclos_q;
    assign instr_count = instr_q;

endmodule

// File: tb/tb_controlador_ejecucion.sv
// tb/tb_controlador_ejecucion.sv - randomized and directed bench for controlador_ejecucion against a behavioural model
module tb_controlador_ejecucion;

    localparam int RST_HOLD = 4;
    localparam int BOOT_RUN = 0;
    localparam int M_HOLD = 0, M_HALTED = 1, M_RUN = 2, M_STEP = 3;

    logic        clk = 1'b0;
    logic        reset, run_req, halt_req, step_req, instr_halt;
    logic [7:0]  step_count;
    logic [31:0] pc;
    logic        bp_valid;
    logic [31:0] bp_addr;
    logic        commit_en, halted;
    logic [1:0]  state, halt_cause;
    logic [31:0] cycle_count, instr_count;

    always #5 clk = ~clk;

    controlador_ejecucion #(
        .ADDR_W(32), .CNT_W(32), .RST_HOLD(RST_HOLD), .BOOT_RUN(BOOT_RUN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef BREAKPOINT_EN
        .bp_valid    (bp_valid),
        .bp_addr     (bp_addr),
`endif
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .step_count  (step_count),
        .pc          (pc),
        .instr_halt  (instr_halt),
        .commit_en   (commit_en),
        .halted      (halted),
        .state       (state),
        .halt_cause  (halt_cause),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: mode, cycles spent in HOLD, instructions left in burst, last cause.
    int          m_state = M_HOLD;
    int          m_hold = 0;
    int          m_rem = 0;
    int          m_cause = 0;
    bit          m_skip = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_ins = '0;
    int          seen = 0;

    function automatic bit m_bp();
        bit b = 1'b0;
`ifdef BREAKPOINT_EN
        b = bp_valid && (pc == bp_addr) && !m_skip && (m_state == M_RUN || m_state == M_STEP);
`endif
        return b;
    endfunction

    function automatic bit m_commit();
        if (reset || m_bp()) return 1'b0;
        return (m_state == M_RUN) || (m_state == M_STEP && m_rem > 0);
    endfunction

    task automatic tick(input bit r, input bit rq, input bit hq, input bit sq,
                        input logic [7:0] sc, input logic [31:0] p, input bit ih);
        bit c, b;
        reset = r; run_req = rq; halt_req = hq; step_req = sq;
        step_count = sc; pc = p; instr_halt = ih;
        #1;
        c = m_commit();
        b = m_bp();
        check("commit_en", {63'd0, commit_en}, {63'd0, c});
        if (m_valid) begin
            check("state", {62'd0, state}, 64'(m_state));
            check("halted", {63'd0, halted}, {63'd0, (m_state == M_HALTED)});
            check("halt_cause", {62'd0, halt_cause}, 64'(m_cause));
            check("cycle_count", {32'd0, cycle_count}, {32'd0, m_cyc});
            check("instr_count", {32'd0, instr_count}, {32'd0, m_ins});
        end
        if (commit_en) seen++;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b1;
            m_state = M_HOLD; m_hold = 0; m_rem = 0; m_cause = 0; m_skip = 1'b0;
            m_cyc = '0; m_ins = '0;
        end else begin
            m_cyc = m_cyc + 1;
            if (c) m_ins = m_ins + 1;
            case (m_state)
                M_HOLD: begin
                    m_hold++;
                    if (m_hold == RST_HOLD) m_state = (BOOT_RUN != 0) ? M_RUN : M_HALTED;
                end
                M_HALTED: begin
                    if (sq) begin
                        m_state = M_STEP; m_rem = (sc == 0) ? 1 : int'(sc); m_skip = 1'b1;
                    end else if (rq) begin
                        m_state = M_RUN; m_skip = 1'b1;
                    end
                end
                default: begin
                    bit last = (m_state == M_STEP) && c && (m_rem == 1);
                    if (c) begin
                        m_skip = 1'b0;
                        if (m_state == M_STEP) m_rem--;
                    end
                    if (hq)        begin m_state = M_HALTED; m_cause = 1; end
                    else if (ih)   begin m_state = M_HALTED; m_cause = 2; end
                    else if (b)    begin m_state = M_HALTED; m_cause = 3; end
                    else if (last) m_state = M_HALTED;
                end
            endcase
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [31:0] p);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 8'd0, p, 0);
    endtask

    initial begin
        logic [31:0] ins0;
        int s0;
        bp_valid = 1'b0;
        bp_addr  = 32'h10;
        @(negedge clk);

        // Reset and boot hold
        seen = 0;
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 1, 8'd2, 32'h0, 0);
        check("rst_commits", 64'(seen), 64'd0);
        check("rst_cycle_count", {32'd0, cycle_count}, 64'd0);
        check("rst_instr_count", {32'd0, instr_count}, 64'd0);
        check("rst_state_hold", {62'd0, state}, 64'd0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 1, 8'd2, 32'h0, 0);
        check("hold_still_hold", {62'd0, state}, 64'd0);
        tick(0, 0, 0, 0, 8'd0, 32'h0, 0);
        check("hold_exit_halted", {62'd0, state}, 64'd1);
        check("hold_exit_cause", {62'd0, halt_cause}, 64'd0);

        // Free run then halt request: halt cycle commits
        seen = 0;
        tick(0, 1, 0, 0, 8'd0, 32'h0, 0);
        idle(10, 32'h4);
        tick(0, 0, 1, 0, 8'd0, 32'h8, 0);
        check("run_commits", 64'(seen), 64'd11);
        check("run_halted", {63'd0, halted}, 64'd1);
        check("run_cause", {62'd0, halt_cause}, 64'd1);

        // Step bursts of 3 and of 0 (treated as 1)
        seen = 0; ins0 = instr_count;
        tick(0, 0, 0, 1, 8'd3, 32'h0, 0);
        idle(5, 32'h4);
        check("step3_commits", 64'(seen), 64'd3);
        check("step3_instr", {32'd0, instr_count - ins0}, 64'd3);
        check("step3_halted", {62'd0, state}, 64'd1);
        check("step3_cause_kept", {62'd0, halt_cause}, 64'd1);
        seen = 0;
        tick(0, 0, 0, 1, 8'd0, 32'h0, 0);
        idle(3, 32'h4);
        check("step0_commits", 64'(seen), 64'd1);

        // Halt instruction at 0x20, then run+halt together in HALTED
        tick(0, 1, 0, 0, 8'd0, 32'h14, 0);
        tick(0, 0, 0, 0, 8'd0, 32'h18, 0);
        tick(0, 0, 0, 0, 8'd0, 32'h1c, 0);
        s0 = seen;
        tick(0, 0, 0, 0, 8'd0, 32'h20, 1);
        check("ihalt_commit", 64'(seen - s0), 64'd1);
        check("ihalt_state", {62'd0, state}, 64'd1);
        check("ihalt_cause", {62'd0, halt_cause}, 64'd2);
        tick(0, 1, 1, 0, 8'd0, 32'h24, 0);
        check("runhalt_both_run", {62'd0, state}, 64'd2);
        tick(0, 0, 1, 0, 8'd0, 32'h28, 0);

`ifdef BREAKPOINT_EN
        bp_valid = 1'b1;
        tick(0, 1, 0, 0, 8'd0, 32'h4, 0);
        tick(0, 0, 0, 0, 8'd0, 32'h8, 0);
        tick(0, 0, 0, 0, 8'd0, 32'hc, 0);
        s0 = seen;
        tick(0, 0, 0, 0, 8'd0, 32'h10, 0);
        check("bp_no_commit", 64'(seen - s0), 64'd0);
        check("bp_cause", {62'd0, halt_cause}, 64'd3);
        check("bp_halted", {62'd0, state}, 64'd1);
        tick(0, 1, 0, 0, 8'd0, 32'h10, 0);
        s0 = seen;
        tick(0, 0, 0, 0, 8'd0, 32'h10, 0);
        check("bp_resume_commit", 64'(seen - s0), 64'd1);
        tick(0, 0, 0, 0, 8'd0, 32'h14, 0);
        tick(0, 0, 0, 0, 8'd0, 32'h10, 0);
        check("bp_rehit_state", {62'd0, state}, 64'd1);
        check("bp_rehit_cause", {62'd0, halt_cause}, 64'd3);
        bp_valid = 1'b0;
`endif

        // Reset in the middle of a step burst
        tick(0, 0, 0, 1, 8'd8, 32'h0, 0);
        idle(3, 32'h4);
        s0 = seen;
        tick(1, 0, 0, 0, 8'd0, 32'h8, 0);
        check("midrst_no_commit", 64'(seen - s0), 64'd0);
        check("midrst_state", {62'd0, state}, 64'd0);
        check("midrst_cycles", {32'd0, cycle_count}, 64'd0);
        check("midrst_instrs", {32'd0, instr_count}, 64'd0);

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 2500; i++) begin
`ifdef BREAKPOINT_EN
            if ($urandom_range(0, 15) == 0) bp_valid = ~bp_valid;
`endif
            tick($urandom_range(0, 299) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 7) == 0,
                 8'($urandom_range(0, 6)),
                 32'($urandom_range(0, 15) * 4),
                 $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
